adder_input_conditioner: RTL and testbench
==========================================

Name: adder_input_conditioner

Overview:
- Front-end stage directly upstream of cra_datapath.
- Takes the raw active-low pushbuttons (LoadB, Run) and the 16 slide switches (Din), and synchronizes all of them to Clk.
- Debounces both keys and emits one-cycle press pulses that drive the datapath's load/run controls.
- Holds a stable snapshot of Din captured at each load press, so switch motion never reaches the adder mid-operation.

Parameters:
DB_CYCLES, 500000, consecutive stable clocks required to accept a key change (10 ms at 50 MHz); minimum legal value 2
DIN_W, 16, width of the switch bus

Ports:
Clk  in  1  system clock, 50 MHz
Reset  in  1  synchronous, active-high reset
LoadB_n  in  1  raw LoadB key, active-low, asynchronous to Clk
Run_n  in  1  raw Run key, active-low, asynchronous to Clk
Din_raw  in  DIN_W  raw slide-switch value, asynchronous to Clk
adder_busy  in  1  high while the datapath is executing an add
Din_sync  out  DIN_W  two-flop synchronized Din_raw, not debounced
Din_hold  out  DIN_W  snapshot of Din_sync taken at each accepted LoadB press
LoadB_pulse  out  1  one-cycle pulse per accepted LoadB press
Run_pulse  out  1  one-cycle pulse per accepted Run press while not busy
run_dropped  out  1  sticky flag: a Run press was discarded because adder_busy was high
key_state  out  2  debounced pressed state {run, loadb}, 1 = pressed

Behaviour:
- Reset (sampled on the Clk rising edge, high):
  - key synchronizer flops load 1 (released); Din synchronizer flops load 0
  - stable key states load released; debounce counters load 0
  - LoadB_pulse, Run_pulse, run_dropped load 0; Din_hold loads 0; key_state loads 2'b00
  - reset takes priority over every other event in the same cycle
- Synchronization:
  - each key and each Din bit passes through two flops
  - Din_sync equals Din_raw as sampled two edges earlier
- Debounce, per key, with counters fully independent:
  - compare the synchronized value with the stable value
  - if they are equal: clear the counter
  - if they differ and counter < DB_CYCLES-1: increment the counter
  - if they differ and counter == DB_CYCLES-1: stable takes the synchronized value and the counter clears
  - net effect: stable flips only after DB_CYCLES consecutive disagreeing clocks
  - any shorter glitch restarts the count and produces no output
- Counter width is clog2(DB_CYCLES); the counter never wraps.
- Pulse generation:
  - a stable transition released->pressed registers a pulse on the next edge, high for exactly one cycle
  - release transitions produce no pulse
  - latency: raw key first sampled at edge 0 -> stable flips at edge DB_CYCLES+1 -> pulse high after edge DB_CYCLES+2, low after DB_CYCLES+3
- A key held indefinitely yields one pulse only; a new pulse requires a debounced release followed by a debounced press.
- Din_hold updates from Din_sync on the same edge that raises LoadB_pulse, so it is valid whenever LoadB_pulse is high. It holds at all other times.
- Run gating:
  - adder_busy is sampled in the cycle the Run stable state flips to pressed
  - if adder_busy is high there: Run_pulse is suppressed, run_dropped sets, and it stays set until Reset
  - no queuing of dropped presses
- Simultaneous events: LoadB and Run are independent, and both pulses may be high in the same cycle. Ordering is the downstream datapath's concern.
- Reset mid-debounce: counters clear and no pulse is produced.
- A key held through reset:
  - the synchronizer reloads pressed after Reset falls and is debounced as a new press
  - the pulse appears DB_CYCLES+3 edges after the first post-reset edge

Test Plan (DB_CYCLES=4):
- Reset high 2 cycles, keys released, Din_raw=16'hFFFF -> all pulses 0, Din_hold=0, key_state=00; Din_sync=16'hFFFF two edges after Reset falls.
- Din_raw=16'h0001, LoadB_n low held 10 cycles -> LoadB_pulse high exactly one cycle, after edge 6 from first sample; Din_hold=16'h0001 that same cycle; key_state[0]=1.
- LoadB_n low for 3 cycles then high (glitch) -> no LoadB_pulse, Din_hold unchanged, key_state[0]=0.
- Run_n low 10 cycles with adder_busy=0 -> single Run_pulse; hold Run_n low 20 more cycles -> no further pulse. Release 10 cycles and press again -> second pulse.
- adder_busy=1 with Run_n pressed 10 cycles -> Run_pulse stays 0, run_dropped=1 and stays 1 after adder_busy falls, until Reset.
- LoadB_n and Run_n pressed on the same edge, Din_raw=16'h0002 -> both pulses high in the same cycle, Din_hold=16'h0002.
- Reset asserted at debounce count 2 -> no pulse; keys still held -> pulse after Reset release plus 7 edges.

Source files
------------

// File: rtl/adder_input_conditioner.sv
// Purpose: synchronize, debounce and edge-detect the LoadB/Run keys; snapshot Din at each load press.
// Latency: Din_sync 2 edges; key press pulse is high after edge DB_CYCLES+2 from the first raw sample.
// Backpressure: none. A Run press that arrives while adder_busy is high is dropped and flagged.
//
// Ports:
//   Clk, Reset        - clock and synchronous active-high reset
//   LoadB_n, Run_n    - raw active-low keys (asynchronous)
//   Din_raw           - raw slide switches (asynchronous)
//   adder_busy        - datapath is executing an add
//   Din_sync          - two-flop synchronized Din_raw
//   Din_hold          - Din_sync captured at each accepted LoadB press
//   LoadB_pulse       - one-cycle pulse per accepted LoadB press
//   Run_pulse         - one-cycle pulse per accepted Run press while not busy
//   run_dropped       - sticky: a Run press was discarded while busy
//   key_state         - debounced pressed state {run, loadb}, 1 = pressed
module adder_input_conditioner #(
  parameter int DB_CYCLES = 500000,
  parameter int DIN_W     = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LoadB_n,
  input  logic             Run_n,
  input  logic [DIN_W-1:0] Din_raw,
  input  logic             adder_busy,
  output logic [DIN_W-1:0] Din_sync,
  output logic [DIN_W-1:0] Din_hold,
  output logic             LoadB_pulse,
  output logic             Run_pulse,
  output logic             run_dropped,
  output logic [1:0]       key_state
);

  localparam int             CW      = $clog2(DB_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

  // Key vectors are indexed [1] = run, [0] = loadb and kept in raw polarity
  // (1 = released) until the output stage.
  logic [1:0]          key_s1_q, key_s1_d;
  logic [1:0]          key_s2_q, key_s2_d;
  logic [1:0]          stable_q, stable_d;
  logic [1:0]          stable_dly_q, stable_dly_d;
  logic [1:0][CW-1:0]  cnt_q, cnt_d;
  logic [DIN_W-1:0]    din_s1_q, din_s1_d;
  logic [DIN_W-1:0]    din_s2_q, din_s2_d;
  logic [DIN_W-1:0]    din_hold_q, din_hold_d;
  logic                loadb_pulse_q, loadb_pulse_d;
  logic                run_pulse_q, run_pulse_d;
  logic                run_dropped_q, run_dropped_d;
  logic [1:0]          press;

  always_comb begin
    key_s1_d      = {Run_n, LoadB_n};
    key_s2_d      = key_s1_q;
    din_s1_d      = Din_raw;
    din_s2_d      = din_s1_q;
    stable_d      = stable_q;
    cnt_d         = cnt_q;
    stable_dly_d  = stable_q;

    // Debounce: stable only follows the synchronized key after DB_CYCLES
    // consecutive disagreeing clocks; any agreement restarts the count.
    for (int k = 0; k < 2; k++) begin
      if (key_s2_q[k] == stable_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CNT_MAX) begin
        stable_d[k] = key_s2_q[k];
        cnt_d[k]    = '0;
      end else begin
        cnt_d[k] = cnt_q[k] + CW'(1);
      end
    end

    // Stable just went released (1) -> pressed (0) on the previous edge.
    press         = stable_dly_q & ~stable_q;

    loadb_pulse_d = press[0];
    run_pulse_d   = press[1] & ~adder_busy;
    run_dropped_d = run_dropped_q | (press[1] & adder_busy);
    din_hold_d    = press[0] ? din_s2_q : din_hold_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      key_s1_q      <= 2'b11;
      key_s2_q      <= 2'b11;
      stable_q      <= 2'b11;
      stable_dly_q  <= 2'b11;
      cnt_q         <= '0;
      din_s1_q      <= '0;
      din_s2_q      <= '0;
      din_hold_q    <= '0;
      loadb_pulse_q <= 1'b0;
      run_pulse_q   <= 1'b0;
      run_dropped_q <= 1'b0;
    end else begin
      key_s1_q      <= key_s1_d;
      key_s2_q      <= key_s2_d;
      stable_q      <= stable_d;
      stable_dly_q  <= stable_dly_d;
      cnt_q         <= cnt_d;
      din_s1_q      <= din_s1_d;
      din_s2_q      <= din_s2_d;
      din_hold_q    <= din_hold_d;
      loadb_pulse_q <= loadb_pulse_d;
      run_pulse_q   <= run_pulse_d;
      run_dropped_q <= run_dropped_d;
    end
  end

  assign Din_sync    = din_s2_q;
  assign Din_hold    = din_hold_q;
  assign LoadB_pulse = loadb_pulse_q;
  assign Run_pulse   = run_pulse_q;
  assign run_dropped = run_dropped_q;
  assign key_state   = ~stable_q;

endmodule

// File: tb/tb_adder_input_conditioner.sv
module tb_adder_input_conditioner;

  localparam int DB  = 4;
  localparam int W   = 16;
  localparam int WIN = 24;
  localparam int NV  = 9;

  logic         clk = 1'b0;
  logic         reset;
  logic         loadb_n;
  logic         run_n;
  logic         busy;
  logic [W-1:0] din_raw;
  logic [W-1:0] din_sync;
  logic [W-1:0] din_hold;
  logic         lb_p;
  logic         run_p;
  logic         drop;
  logic [1:0]   ks;

  always #5 clk = ~clk;

  adder_input_conditioner #(.DB_CYCLES(DB), .DIN_W(W)) dut (
    .Clk        (clk),
    .Reset      (reset),
    .LoadB_n    (loadb_n),
    .Run_n      (run_n),
    .Din_raw    (din_raw),
    .adder_busy (busy),
    .Din_sync   (din_sync),
    .Din_hold   (din_hold),
    .LoadB_pulse(lb_p),
    .Run_pulse  (run_p),
    .run_dropped(drop),
    .key_state  (ks)
  );

  typedef struct {
    int          lb_len;
    int          run_len;
    logic        busy;
    logic [15:0] din;
    int          exp_lb_cnt;
    int          exp_lb_at;
    int          exp_run_cnt;
    int          exp_run_at;
    logic [15:0] exp_hold;
    logic        exp_drop;
    logic [1:0]  exp_ks6;
  } vec_t;

  vec_t vecs [NV];
  vec_t sb_q [$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Advance one rising edge and land 1 time unit after it for sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   lb_cnt, run_cnt, lb_at, run_at;
    logic [15:0] hold_at;
    logic [1:0]  ks6;
    vec_t e;

    //              lb  run busy din       lbc lb@ rnc rn@ hold      drop  ks6
    vecs[0] = '{10, 0,  1'b0, 16'h0001, 1,  6,  0, -1, 16'h0001, 1'b0, 2'b01};
    vecs[1] = '{3,  0,  1'b0, 16'h00AA, 0, -1,  0, -1, 16'h0001, 1'b0, 2'b00};
    vecs[2] = '{4,  0,  1'b0, 16'h0003, 1,  6,  0, -1, 16'h0003, 1'b0, 2'b01};
    vecs[3] = '{0,  10, 1'b0, 16'h0004, 0, -1,  1,  6, 16'h0003, 1'b0, 2'b10};
    vecs[4] = '{0,  3,  1'b0, 16'h0008, 0, -1,  0, -1, 16'h0003, 1'b0, 2'b00};
    vecs[5] = '{10, 10, 1'b0, 16'h0002, 1,  6,  1,  6, 16'h0002, 1'b0, 2'b11};
    vecs[6] = '{0,  10, 1'b1, 16'h0005, 0, -1,  0, -1, 16'h0002, 1'b1, 2'b10};
    vecs[7] = '{0,  10, 1'b0, 16'h0006, 0, -1,  1,  6, 16'h0002, 1'b1, 2'b10};
    vecs[8] = '{10, 10, 1'b1, 16'h0007, 1,  6,  0, -1, 16'h0007, 1'b1, 2'b11};

    // Reset with keys released and switches all high.
    reset   = 1'b1;
    loadb_n = 1'b1;
    run_n   = 1'b1;
    busy    = 1'b0;
    din_raw = 16'hFFFF;
    step();
    step();
    chk("rst_lb_pulse", {31'b0, lb_p}, 32'd0);
    chk("rst_run_pulse", {31'b0, run_p}, 32'd0);
    chk("rst_drop", {31'b0, drop}, 32'd0);
    chk("rst_hold", {16'b0, din_hold}, 32'h0);
    chk("rst_ks", {30'b0, ks}, 32'd0);
    chk("rst_din_sync", {16'b0, din_sync}, 32'h0);
    reset = 1'b0;
    step();
    chk("din_sync_edge1", {16'b0, din_sync}, 32'h0);
    step();
    chk("din_sync_edge2", {16'b0, din_sync}, 32'hFFFF);

    // Table vectors: keys low for lb_len/run_len edges starting at edge 0.
    for (int n = 0; n < NV; n++) begin
      sb_q.push_back(vecs[n]);
      lb_cnt  = 0;
      run_cnt = 0;
      lb_at   = -1;
      run_at  = -1;
      hold_at = 16'hDEAD;
      ks6     = 2'bxx;
      busy    = vecs[n].busy;
      din_raw = vecs[n].din;
      for (int i = 0; i < WIN; i++) begin
        loadb_n = !(i < vecs[n].lb_len);
        run_n   = !(i < vecs[n].run_len);
        step();
        if (lb_p) begin
          lb_cnt++;
          lb_at   = i;
          hold_at = din_hold;
        end
        if (run_p) begin
          run_cnt++;
          run_at = i;
        end
        if (i == 1) chk($sformatf("v%0d_din_sync", n), {16'b0, din_sync}, {16'b0, vecs[n].din});
        if (i == 6) ks6 = ks;
      end
      busy = 1'b0;
      e = sb_q.pop_front();
      chk($sformatf("v%0d_lb_cnt", n), lb_cnt, e.exp_lb_cnt);
      chk($sformatf("v%0d_lb_at", n), lb_at, e.exp_lb_at);
      chk($sformatf("v%0d_run_cnt", n), run_cnt, e.exp_run_cnt);
      chk($sformatf("v%0d_run_at", n), run_at, e.exp_run_at);
      if (e.exp_lb_cnt == 1) chk($sformatf("v%0d_hold_at_pulse", n), {16'b0, hold_at}, {16'b0, e.exp_hold});
      chk($sformatf("v%0d_hold", n), {16'b0, din_hold}, {16'b0, e.exp_hold});
      chk($sformatf("v%0d_drop", n), {31'b0, drop}, {31'b0, e.exp_drop});
      chk($sformatf("v%0d_ks6", n), {30'b0, ks6}, {30'b0, e.exp_ks6});
      chk($sformatf("v%0d_ks_end", n), {30'b0, ks}, 32'd0);
    end

    // Run held for a long time: one pulse only; release then press again.
    run_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      run_n = 1'b0;
      step();
      if (run_p) run_cnt++;
    end
    chk("held_run_cnt", run_cnt, 1);
    run_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      run_n = 1'b1;
      step();
      if (run_p) run_cnt++;
    end
    chk("release_run_cnt", run_cnt, 0);
    run_cnt = 0;
    for (int i = 0; i < 22; i++) begin
      run_n = !(i < 10);
      step();
      if (run_p) run_cnt++;
    end
    chk("repress_run_cnt", run_cnt, 1);

    // Reset at debounce count 2 with both keys held through reset.
    din_raw = 16'h0055;
    lb_cnt  = 0;
    run_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      loadb_n = 1'b0;
      run_n   = 1'b0;
      step();
      if (lb_p) lb_cnt++;
      if (run_p) run_cnt++;
    end
    reset = 1'b1;
    step();
    step();
    if (lb_p) lb_cnt++;
    if (run_p) run_cnt++;
    chk("mid_rst_no_lb", lb_cnt, 0);
    chk("mid_rst_no_run", run_cnt, 0);
    chk("mid_rst_drop_clr", {31'b0, drop}, 32'd0);
    chk("mid_rst_hold", {16'b0, din_hold}, 32'h0);
    chk("mid_rst_ks", {30'b0, ks}, 32'd0);
    reset   = 1'b0;
    lb_at   = -1;
    run_at  = -1;
    hold_at = 16'hDEAD;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (lb_p) begin
        lb_cnt++;
        lb_at   = i;
        hold_at = din_hold;
      end
      if (run_p) begin
        run_cnt++;
        run_at = i;
      end
    end
    chk("post_rst_lb_cnt", lb_cnt, 1);
    chk("post_rst_lb_at", lb_at, 7);
    chk("post_rst_run_cnt", run_cnt, 1);
    chk("post_rst_run_at", run_at, 7);
    chk("post_rst_hold", {16'b0, hold_at}, 32'h0055);
    chk("post_rst_ks", {30'b0, ks}, 32'd3);

    loadb_n = 1'b1;
    run_n   = 1'b1;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
